// File: rtl/misr_sig_analyzer.sv
// misr_sig_analyzer: compacts a fixed count of multiplier products into a Galois MISR signature
// and reports a registered pass/fail verdict against a golden value.
module misr_sig_analyzer #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] POLY     = 8'h1D,
    parameter logic [WIDTH-1:0] SEED     = 8'h00,
    parameter int               PATTERNS = 256,
    parameter logic [WIDTH-1:0] GOLDEN   = 8'hDE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [31:0]      verdict,
    output logic [15:0]      count
);
    typedef enum logic [1:0] {IDLE, COMPACT, COMPARE, DONE} state_t;
    localparam logic [31:0] PASS_WORD = 32'h50415353;
    localparam logic [31:0] FAIL_WORD = 32'h4641494C;
    localparam logic [15:0] LAST = 16'(PATTERNS - 1);
    state_t state;
    logic [WIDTH-1:0] next_sig;
    assign next_sig = {signature[WIDTH-2:0], 1'b0} ^ (signature[WIDTH-1] ? POLY : '0) ^ resp;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            signature <= SEED;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            verdict   <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state     <= COMPACT;
                    signature <= SEED;
                    count     <= '0;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    pass      <= 1'b0;
                    verdict   <= '0;
                end
                COMPACT: if (resp_valid) begin
                    signature <= next_sig;
                    count     <= count + 16'd1;
                    if (count == LAST) state <= COMPARE;
                end
                COMPARE: begin
                    pass    <= signature == GOLDEN;
                    verdict <= (signature == GOLDEN) ? PASS_WORD : FAIL_WORD;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_misr_sig_analyzer.sv
// tb_misr_sig_analyzer: directed vectors for a PATTERNS=2 instance plus long-run and
// mid-run reset sequences on a default-parameter instance.
module tb_misr_sig_analyzer;
    localparam logic [31:0] PW = 32'h50415353;
    localparam logic [31:0] FW = 32'h4641494C;
    logic clk = 1'b0;
    logic rst, start_a, start_b, resp_valid;
    logic [7:0] resp;
    logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [7:0] sig_a, sig_b;
    logic [31:0] verd_a, verd_b;
    logic [15:0] cnt_a, cnt_b;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    misr_sig_analyzer #(.PATTERNS(2), .GOLDEN(8'h1D)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .resp_valid(resp_valid), .resp(resp),
        .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a),
        .verdict(verd_a), .count(cnt_a));

    misr_sig_analyzer dut_b (
        .clk(clk), .rst(rst), .start(start_b), .resp_valid(resp_valid), .resp(resp),
        .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b),
        .verdict(verd_b), .count(cnt_b));

    typedef struct packed {
        logic        st;
        logic        v;
        logic [7:0]  r;
        logic [7:0]  sig;
        logic [15:0] cnt;
        logic        busy;
        logic        done;
        logic        pass;
        logic [31:0] verd;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic sa, input logic sb, input logic v, input logic [7:0] r);
        start_a = sa;
        start_b = sb;
        resp_valid = v;
        resp = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gal(input logic [7:0] s, input logic [7:0] r);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ r;
    endfunction

    initial begin
        // start, valid, resp | signature, count, busy, done, pass, verdict (after the edge)
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 16'd0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 8'h80, 8'h80, 16'd1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 8'h00, 8'h1D, 16'd2, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 8'hFF, 8'h1D, 16'd2, 1'b0, 1'b1, 1'b1, PW};
        tbl[4]  = '{1'b0, 1'b1, 8'h33, 8'h1D, 16'd2, 1'b0, 1'b1, 1'b1, PW};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 8'h00, 16'd0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 8'h80, 8'h80, 16'd1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 8'hFF, 8'hE2, 16'd2, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 8'hE2, 16'd2, 1'b0, 1'b1, 1'b0, FW};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 8'h00, 16'd0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 8'h80, 8'h80, 16'd1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 8'hAA, 8'h80, 16'd1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 1'b0, 8'hAA, 8'h80, 16'd1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 8'hAA, 8'h80, 16'd1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 1'b1, 8'h00, 8'h1D, 16'd2, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 8'h1D, 16'd2, 1'b0, 1'b1, 1'b1, PW};

        rst = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        resp_valid = 1'b0;
        resp = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sig", 32'(sig_a), 32'h00);
        chk("rst_cnt", 32'(cnt_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_pass", 32'(pass_a), 32'd0);
        chk("rst_verdict", verd_a, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b0, 1'b1, 8'hAA);
        chk("idle_sig_a", 32'(sig_a), 32'h00);
        chk("idle_cnt_a", 32'(cnt_a), 32'd0);
        chk("idle_sig_b", 32'(sig_b), 32'h00);
        chk("idle_busy_b", 32'(busy_b), 32'd0);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].st, 1'b0, tbl[i].v, tbl[i].r);
            chk($sformatf("row%0d_sig", i), 32'(sig_a), 32'(tbl[i].sig));
            chk($sformatf("row%0d_cnt", i), 32'(cnt_a), 32'(tbl[i].cnt));
            chk($sformatf("row%0d_busy", i), 32'(busy_a), 32'(tbl[i].busy));
            chk($sformatf("row%0d_done", i), 32'(done_a), 32'(tbl[i].done));
            chk($sformatf("row%0d_pass", i), 32'(pass_a), 32'(tbl[i].pass));
            chk($sformatf("row%0d_verdict", i), verd_a, tbl[i].verd);
        end

        // 100 accepts on the 256-pattern instance, with a stray start in the middle
        begin
            logic [7:0] m;
            m = 8'h00;
            step(1'b0, 1'b1, 1'b0, 8'h00);
            chk("b_busy_after_start", 32'(busy_b), 32'd1);
            for (int i = 0; i < 100; i++) begin
                step(1'b0, i == 50, 1'b1, 8'(i * 7 + 3));
                m = gal(m, 8'(i * 7 + 3));
            end
            chk("b_cnt_100", 32'(cnt_b), 32'd100);
            chk("b_sig_100", 32'(sig_b), 32'(m));
            chk("b_busy_100", 32'(busy_b), 32'd1);
            chk("b_done_100", 32'(done_b), 32'd0);
        end
        #2 rst = 1'b0;
        #1;
        chk("arst_sig_b", 32'(sig_b), 32'h00);
        chk("arst_cnt_b", 32'(cnt_b), 32'd0);
        chk("arst_busy_b", 32'(busy_b), 32'd0);
        chk("arst_done_b", 32'(done_b), 32'd0);
        chk("arst_verdict_b", verd_b, 32'h0);
        chk("arst_done_a", 32'(done_a), 32'd0);
        chk("arst_pass_a", 32'(pass_a), 32'd0);
        chk("arst_verdict_a", verd_a, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("post_rst_verdict_b", verd_b, 32'h0);

        // full 256-pattern run of zeros: signature stays at seed, which is not golden
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("full_cnt", 32'(cnt_b), 32'd256);
        chk("full_busy", 32'(busy_b), 32'd1);
        chk("full_done_early", 32'(done_b), 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("full_done", 32'(done_b), 32'd1);
        chk("full_pass", 32'(pass_b), 32'd0);
        chk("full_verdict", verd_b, FW);
        chk("full_sig", 32'(sig_b), 32'h00);
        step(1'b0, 1'b0, 1'b1, 8'h11);
        chk("full_cnt_frozen", 32'(cnt_b), 32'd256);
        chk("full_sig_frozen", 32'(sig_b), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
